// File: rtl/forward_hazard_unit_pkg.sv
// rtl/forward_hazard_unit_pkg.sv - shared core types for operand forwarding and hazard detection
package forward_hazard_unit_pkg;

    localparam int CORE_XLEN       = 32;
    localparam int CORE_REG_ADDR_W = 5;
    localparam int CORE_FWD_DEPTH  = 2;

    // Tags carry a fixed-width rd so the struct is shared by every REG_ADDR_W up to 8.
    localparam int TAG_RD_W = 8;

    localparam int FWD_RF      = 0;
    localparam int DEF_FWD_BYP = CORE_FWD_DEPTH + 1;
    localparam int DEF_SEL_W   = $clog2(CORE_FWD_DEPTH + 2);

    typedef struct packed {
        logic                valid;
        logic [TAG_RD_W-1:0] rd;
        logic                regWrite;
        logic                memRead;
    } fwd_tag_t;

    function automatic int fwdSelWidth(input int fwdDepth);
        return $clog2(fwdDepth + 2);
    endfunction

    function automatic int fwdBypCode(input int fwdDepth);
        return fwdDepth + 1;
    endfunction

    function automatic logic tagMatch(input fwd_tag_t tag, input logic [TAG_RD_W-1:0] rs);
        return tag.valid && tag.regWrite && (tag.rd == rs);
    endfunction

endpackage

// File: rtl/fwd_operand_mux.sv
// rtl/fwd_operand_mux.sv - per-source EX operand select: register file, pipeline stage or WB bypass
module fwd_operand_mux
    import forward_hazard_unit_pkg::*;
#(
    parameter int XLEN      = CORE_XLEN,
    parameter int FWD_DEPTH = CORE_FWD_DEPTH,
    parameter int WB_BYPASS = 1,
    parameter int SEL_W     = DEF_SEL_W
) (
    input  logic [SEL_W-1:0]          sel,
    input  logic [XLEN-1:0]           rfData,
    input  logic [FWD_DEPTH*XLEN-1:0] stageResult,
    input  logic [XLEN-1:0]           bypassData,
    output logic [XLEN-1:0]           operand
);

    always_comb begin
        operand = '0;
        if (sel == SEL_W'(FWD_RF)) begin
            operand = rfData;
        end
        for (int k = 1; k <= FWD_DEPTH; k++) begin
            if (sel == SEL_W'(k)) begin
                operand = stageResult[(k-1)*XLEN +: XLEN];
            end
        end
        if ((WB_BYPASS != 0) && (sel == SEL_W'(fwdBypCode(FWD_DEPTH)))) begin
            operand = bypassData;
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// rtl/forward_hazard_unit.sv - tag pipeline, decode-time forward selects, load-use stall and stall counter
module forward_hazard_unit
    import forward_hazard_unit_pkg::*;
#(
    parameter int XLEN        = CORE_XLEN,
    parameter int NUM_SRC     = 2,
    parameter int REG_ADDR_W  = CORE_REG_ADDR_W,
    parameter int FWD_DEPTH   = CORE_FWD_DEPTH,
    parameter int WB_BYPASS   = 1,
    parameter int STALL_CNT_W = 16,
    localparam int SEL_W      = fwdSelWidth(FWD_DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pipeHold,
    input  logic                          exFlush,
    input  logic                          idValid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] idRs,
    input  logic [NUM_SRC-1:0]            idRsUsed,
    input  logic [REG_ADDR_W-1:0]         idRd,
    input  logic                          idRegWrite,
    input  logic                          idMemRead,
    input  logic [NUM_SRC*XLEN-1:0]       exReadData,
    input  logic [FWD_DEPTH*XLEN-1:0]     stageResult,
    output logic [NUM_SRC*XLEN-1:0]       aluOperand,
    output logic [NUM_SRC*SEL_W-1:0]      fwdSel,
    output logic                          stall,
    output logic [STALL_CNT_W-1:0]        stallCount
);

    localparam logic [SEL_W-1:0] SEL_BYP = SEL_W'(fwdBypCode(FWD_DEPTH));

    fwd_tag_t                        tags [FWD_DEPTH+1];
    fwd_tag_t                        decTag;
    logic [NUM_SRC-1:0][SEL_W-1:0]   decSel;
    logic [NUM_SRC-1:0]              loadUse;
    logic [TAG_RD_W-1:0]             rs;
    logic                            srcActive;
    logic                            loadTag;
    logic [XLEN-1:0]                 bypass [NUM_SRC];
    logic [NUM_SRC*SEL_W-1:0]        selQ;
    logic [STALL_CNT_W-1:0]          stallCountQ;

    // Scan from WB towards EX so the youngest producer is assigned last and wins.
    always_comb begin
        decSel    = '0;
        loadUse   = '0;
        rs        = '0;
        srcActive = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rs        = TAG_RD_W'(idRs[i*REG_ADDR_W +: REG_ADDR_W]);
            srcActive = idRsUsed[i] && (rs != '0);
            for (int j = FWD_DEPTH; j >= 0; j--) begin
                if (srcActive && tagMatch(tags[j], rs)) begin
                    if (j < FWD_DEPTH) begin
                        decSel[i] = SEL_W'(j + 1);
                    end else if (WB_BYPASS != 0) begin
                        decSel[i] = SEL_BYP;
                    end
                end
            end
            loadUse[i] = srcActive && tagMatch(tags[0], rs) && tags[0].memRead;
        end
    end

    assign stall   = idValid && !exFlush && (|loadUse);
    assign loadTag = idValid && !stall && !exFlush;
    assign decTag  = '{valid: 1'b1, rd: TAG_RD_W'(idRd), regWrite: idRegWrite, memRead: idMemRead};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= FWD_DEPTH; k++) begin
                tags[k] <= '0;
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                bypass[i] <= '0;
            end
            selQ        <= '0;
            stallCountQ <= '0;
        end else if (!pipeHold) begin
            tags[0] <= loadTag ? decTag : '0;
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                tags[k] <= tags[k-1];
            end
            selQ <= loadTag ? decSel : '0;
            // The WB instruction retires this edge, so its result must be held for EX.
            for (int i = 0; i < NUM_SRC; i++) begin
                if (loadTag && (decSel[i] == SEL_BYP)) begin
                    bypass[i] <= stageResult[(FWD_DEPTH-1)*XLEN +: XLEN];
                end
            end
            if (stall && (stallCountQ != '1)) begin
                stallCountQ <= stallCountQ + 1'b1;
            end
        end
    end

    assign fwdSel     = selQ;
    assign stallCount = stallCountQ;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_operand_mux #(
            .XLEN      (XLEN),
            .FWD_DEPTH (FWD_DEPTH),
            .WB_BYPASS (WB_BYPASS),
            .SEL_W     (SEL_W)
        ) u_mux (
            .sel         (selQ[i*SEL_W +: SEL_W]),
            .rfData      (exReadData[i*XLEN +: XLEN]),
            .stageResult (stageResult),
            .bypassData  (bypass[i]),
            .operand     (aluOperand[i*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// tb/tb_forward_hazard_unit.sv - directed self-checking bench for forward_hazard_unit
module tb_forward_hazard_unit;

    localparam logic [31:0] RF0 = 32'hAAAA_0000;
    localparam logic [31:0] RF1 = 32'hBBBB_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipeHold;
    logic        exFlush;
    logic        idValid;
    logic [9:0]  idRs;
    logic [1:0]  idRsUsed;
    logic [4:0]  idRd;
    logic        idRegWrite;
    logic        idMemRead;
    logic [63:0] exReadData;
    logic [63:0] stageResult;
    logic [63:0] aluOperand;
    logic [3:0]  fwdSel;
    logic        stall;
    logic [1:0]  stallCount;

    int checks   = 0;
    int failures = 0;
    int expCnt;

    always #5 clk = ~clk;

    forward_hazard_unit #(
        .XLEN        (32),
        .NUM_SRC     (2),
        .REG_ADDR_W  (5),
        .FWD_DEPTH   (2),
        .WB_BYPASS   (1),
        .STALL_CNT_W (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pipeHold    (pipeHold),
        .exFlush     (exFlush),
        .idValid     (idValid),
        .idRs        (idRs),
        .idRsUsed    (idRsUsed),
        .idRd        (idRd),
        .idRegWrite  (idRegWrite),
        .idMemRead   (idMemRead),
        .exReadData  (exReadData),
        .stageResult (stageResult),
        .aluOperand  (aluOperand),
        .fwdSel      (fwdSel),
        .stall       (stall),
        .stallCount  (stallCount)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [1:0]  used;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic [31:0] s0;
        logic [31:0] s1;
        logic        eStall;
        logic [1:0]  eSel0;
        logic [1:0]  eSel1;
        logic [31:0] eOp0;
        logic [31:0] eOp1;
        logic [1:0]  eCnt;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [1:0] used, input logic [4:0] rd, input logic rw, input logic mr);
        idValid    = v;
        idRs       = {rs2, rs1};
        idRsUsed   = used;
        idRd       = rd;
        idRegWrite = rw;
        idMemRead  = mr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          v  rs1 rs2 used   rd  rw mr  s0          s1            stall sel0 sel1 op0           op1     cnt
        vecs[0]  = '{1, 0,  0,  2'b00, 5,  1, 0, 32'h0,      32'h0,        0,    0,   0,   RF0,          RF1,    0};
        vecs[1]  = '{1, 5,  0,  2'b01, 6,  1, 0, 32'h0,      32'h0,        0,    0,   0,   RF0,          RF1,    0};
        vecs[2]  = '{1, 0,  5,  2'b10, 9,  1, 0, 32'h7,      32'h0,        0,    1,   0,   32'h7,        RF1,    0};
        vecs[3]  = '{1, 9,  6,  2'b11, 6,  1, 0, 32'h0,      32'h55,       0,    0,   2,   RF0,          32'h55, 0};
        vecs[4]  = '{1, 0,  6,  2'b10, 10, 1, 0, 32'h11,     32'h22,       0,    1,   2,   32'h11,       32'h22, 0};
        vecs[5]  = '{1, 0,  0,  2'b00, 0,  1, 0, 32'h33,     32'h0,        0,    0,   1,   RF0,          32'h33, 0};
        vecs[6]  = '{1, 0,  10, 2'b01, 0,  0, 0, 32'h0,      32'h0,        0,    0,   0,   RF0,          RF1,    0};
        vecs[7]  = '{1, 0,  0,  2'b00, 7,  1, 1, 32'h0,      32'h0,        0,    0,   0,   RF0,          RF1,    0};
        vecs[8]  = '{1, 7,  0,  2'b01, 11, 1, 0, 32'h0,      32'h0,        1,    0,   0,   RF0,          RF1,    0};
        vecs[9]  = '{1, 7,  0,  2'b01, 11, 1, 0, 32'h0,      32'h0,        0,    0,   0,   RF0,          RF1,    1};
        vecs[10] = '{1, 0,  0,  2'b00, 12, 1, 0, 32'h0,      32'hDEADBEEF, 0,    2,   0,   32'hDEADBEEF, RF1,    1};
        vecs[11] = '{1, 0,  0,  2'b00, 13, 1, 0, 32'h0,      32'h0,        0,    0,   0,   RF0,          RF1,    1};
        vecs[12] = '{1, 0,  11, 2'b10, 14, 1, 0, 32'h0,      32'h1234,     0,    0,   0,   RF0,          RF1,    1};
        vecs[13] = '{0, 0,  0,  2'b00, 0,  0, 0, 32'h0,      32'h9999,     0,    0,   3,   RF0,          32'h1234, 1};

        rst_n       = 1'b0;
        pipeHold    = 1'b0;
        exFlush     = 1'b0;
        exReadData  = {RF1, RF0};
        stageResult = '0;
        drive(0, 0, 0, 2'b00, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset.stall", 32'(stall), 32'h0);
        check("reset.fwdSel", 32'(fwdSel), 32'h0);
        check("reset.stallCount", 32'(stallCount), 32'h0);
        check("reset.op0", aluOperand[31:0], RF0);
        check("reset.op1", aluOperand[63:32], RF1);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].valid, vecs[i].rs1, vecs[i].rs2, vecs[i].used, vecs[i].rd, vecs[i].rw, vecs[i].mr);
            stageResult = {vecs[i].s1, vecs[i].s0};
            #1;
            check($sformatf("v%0d.stall", i), 32'(stall), 32'(vecs[i].eStall));
            check($sformatf("v%0d.sel0", i), 32'(fwdSel[1:0]), 32'(vecs[i].eSel0));
            check($sformatf("v%0d.sel1", i), 32'(fwdSel[3:2]), 32'(vecs[i].eSel1));
            check($sformatf("v%0d.op0", i), aluOperand[31:0], vecs[i].eOp0);
            check($sformatf("v%0d.op1", i), aluOperand[63:32], vecs[i].eOp1);
            check($sformatf("v%0d.cnt", i), 32'(stallCount), 32'(vecs[i].eCnt));
            @(posedge clk);
            #1;
        end

        // Hold: a load enters EX, then a dependent decode waits under pipeHold.
        stageResult = '0;
        drive(1, 14, 0, 2'b01, 15, 1, 1);
        tick();
        for (int h = 0; h < 3; h++) begin
            pipeHold = 1'b1;
            drive(1, 15, 0, 2'b01, 16, 1, 0);
            #1;
            check($sformatf("hold%0d.stall", h), 32'(stall), 32'h1);
            check($sformatf("hold%0d.sel0", h), 32'(fwdSel[1:0]), 32'h2);
            check($sformatf("hold%0d.cnt", h), 32'(stallCount), 32'h1);
            @(posedge clk);
            #1;
        end
        pipeHold = 1'b0;
        #1;
        check("holdRelease.stall", 32'(stall), 32'h1);
        tick();
        check("postHold.cnt", 32'(stallCount), 32'h2);
        check("postHold.sel", 32'(fwdSel), 32'h0);
        check("postHold.stall", 32'(stall), 32'h0);

        // Flush during a load-use: stall drops and EX receives a bubble.
        drive(1, 15, 0, 2'b00, 17, 1, 1);
        tick();
        exFlush = 1'b1;
        drive(1, 17, 0, 2'b01, 18, 1, 1);
        #1;
        check("flush.stall", 32'(stall), 32'h0);
        tick();
        exFlush = 1'b0;
        #1;
        check("flushBubble.stall", 32'(stall), 32'h0);
        check("flushBubble.sel", 32'(fwdSel), 32'h0);
        check("flushBubble.cnt", 32'(stallCount), 32'h2);
        tick();
        check("afterFlush.sel0", 32'(fwdSel[1:0]), 32'h2);

        // Reset in the middle of a load-use with live forwarding state.
        drive(1, 18, 0, 2'b01, 19, 1, 0);
        stageResult = {32'h77, 32'h66};
        #1;
        check("preReset.stall", 32'(stall), 32'h1);
        rst_n = 1'b0;
        #1;
        check("midReset.stall", 32'(stall), 32'h0);
        check("midReset.sel", 32'(fwdSel), 32'h0);
        check("midReset.cnt", 32'(stallCount), 32'h0);
        check("midReset.op0", aluOperand[31:0], RF0);
        check("midReset.op1", aluOperand[63:32], RF1);
        tick();
        rst_n = 1'b1;
        #1;
        check("afterReset.stall", 32'(stall), 32'h0);
        tick();
        check("afterReset.sel", 32'(fwdSel), 32'h0);
        check("afterReset.op0", aluOperand[31:0], RF0);

        // Saturation of the 2-bit stall counter over five load-use stalls.
        expCnt = 0;
        for (int n = 0; n < 5; n++) begin
            drive(1, 0, 0, 2'b00, 20, 1, 1);
            tick();
            drive(1, 20, 0, 2'b01, 21, 1, 0);
            #1;
            check($sformatf("sat%0d.stall", n), 32'(stall), 32'h1);
            tick();
            expCnt = (expCnt < 3) ? expCnt + 1 : 3;
            check($sformatf("sat%0d.cnt", n), 32'(stallCount), 32'(expCnt));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
